// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for load-use, taken-branch and data-memory-wait hazards.
// Latency: control outputs are combinational in the same cycle; state, timeout and counters update on the next edge.
// Backpressure: a memory wait freezes PC..EX/MEM and bubbles MEM/WB; FAULT freezes everything until rst.
module hazard_stall_unit #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memRead,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [15:0] MAX_WAIT_L = 16'(MAX_WAIT);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        timeout_nxt;
    logic        wait_now;
    logic        rs1_hit, rs2_hit, lu;
    logic [15:0] frozen_incl_now;

    assign wait_now = mem_req & ~mem_ready;
    assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
    assign lu       = ex_memRead & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

    // wait_cnt holds frozen cycles already completed; the current cycle is one more.
    assign frozen_incl_now = wait_cnt + 16'd1;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (state == FAULT) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (wait_now) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            // The squashed ID instruction makes any load-use match irrelevant.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = mem_timeout;
        case (state)
            RUN: begin
                wait_cnt_nxt = 16'd0;
                if (wait_now) begin
                    if (MAX_WAIT_L <= 16'd1) begin
                        state_nxt   = FAULT;
                        timeout_nxt = 1'b1;
                    end else begin
                        state_nxt = MEM_WAIT;
                    end
                    wait_cnt_nxt = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (!wait_now) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 16'd0;
                end else if (frozen_incl_now >= MAX_WAIT_L) begin
                    state_nxt   = FAULT;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = frozen_incl_now;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: default, short-timeout and narrow-counter instances share stimulus.
// Latency: outputs checked mid-cycle; Backpressure: n/a.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_memRead, ex_branch_taken, mem_req, mem_ready;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write, a_idex_bubble;
    logic        a_exmem_write, a_memwb_bubble, a_mem_timeout;
    logic [15:0] a_stall_count;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_write, b_idex_bubble;
    logic        b_exmem_write, b_memwb_bubble, b_mem_timeout;
    logic [15:0] b_stall_count;
    logic        c_pc_write, c_ifid_write, c_ifid_flush, c_idex_write, c_idex_bubble;
    logic        c_exmem_write, c_memwb_bubble, c_mem_timeout;
    logic [3:0]  c_stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_stall_unit u_dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_memRead(ex_memRead), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .idex_write(a_idex_write), .idex_bubble(a_idex_bubble), .exmem_write(a_exmem_write),
        .memwb_bubble(a_memwb_bubble), .mem_timeout(a_mem_timeout), .stall_count(a_stall_count)
    );

    hazard_stall_unit #(.MAX_WAIT(4)) u_to (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_memRead(ex_memRead), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .idex_write(b_idex_write), .idex_bubble(b_idex_bubble), .exmem_write(b_exmem_write),
        .memwb_bubble(b_memwb_bubble), .mem_timeout(b_mem_timeout), .stall_count(b_stall_count)
    );

    hazard_stall_unit #(.MAX_WAIT(255), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_memRead(ex_memRead), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(c_pc_write), .ifid_write(c_ifid_write), .ifid_flush(c_ifid_flush),
        .idex_write(c_idex_write), .idex_bubble(c_idex_bubble), .exmem_write(c_exmem_write),
        .memwb_bubble(c_memwb_bubble), .mem_timeout(c_mem_timeout), .stall_count(c_stall_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_memRead = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        // {pc,ifid,idex,exmem writes, ifid_flush, idex_bubble, memwb_bubble}
        n_cmp++; if ({a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_ifid_flush, a_idex_bubble, a_memwb_bubble} !== 7'b0000111) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000111", {a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_ifid_flush, a_idex_bubble, a_memwb_bubble});
        end
        step();
        n_cmp++; if (a_stall_count !== 16'd0 || a_mem_timeout !== 1'b0) begin
            n_bad++; $display("FAIL reset_state: got cnt=%0d to=%b want cnt=0 to=0", a_stall_count, a_mem_timeout);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if ({a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_ifid_flush, a_idex_bubble, a_memwb_bubble} !== 7'b1111000) begin
            n_bad++; $display("FAIL idle_ctrl: got %b want 1111000", {a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_ifid_flush, a_idex_bubble, a_memwb_bubble});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #1;
        // {pc_write, ifid_write, idex_write, idex_bubble, exmem_write, ifid_flush}
        n_cmp++; if ({a_pc_write, a_ifid_write, a_idex_write, a_idex_bubble, a_exmem_write, a_ifid_flush} !== 6'b001110) begin
            n_bad++; $display("FAIL lu_rs2_ctrl: got %b want 001110", {a_pc_write, a_ifid_write, a_idex_write, a_idex_bubble, a_exmem_write, a_ifid_flush});
        end
        step();
        n_cmp++; if (a_stall_count !== 16'd1) begin
            n_bad++; $display("FAIL lu_count: got %0d want 1", a_stall_count);
        end
        ex_memRead = 1'b0;
        #1;
        n_cmp++; if (a_pc_write !== 1'b1 || a_idex_bubble !== 1'b0) begin
            n_bad++; $display("FAIL lu_release: got pc_write=%b bubble=%b want 1 0", a_pc_write, a_idex_bubble);
        end
        step();
        ex_memRead = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
        #1;
        n_cmp++; if (a_pc_write !== 1'b0 || a_idex_bubble !== 1'b1) begin
            n_bad++; $display("FAIL lu_rs1: got pc_write=%b bubble=%b want 0 1", a_pc_write, a_idex_bubble);
        end
        step();
        n_cmp++; if (a_stall_count !== 16'd2) begin
            n_bad++; $display("FAIL lu_count2: got %0d want 2", a_stall_count);
        end
    endtask

    task automatic test_no_stall();
        do_reset();
        ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1;
        n_cmp++; if ({a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_idex_bubble} !== 5'b11110) begin
            n_bad++; $display("FAIL x0_nostall: got %b want 11110", {a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_idex_bubble});
        end
        step();
        ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0; id_rs2 = 5'd9; id_uses_rs2 = 1'b0;
        #1;
        n_cmp++; if ({a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_idex_bubble} !== 5'b11110) begin
            n_bad++; $display("FAIL unused_nostall: got %b want 11110", {a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_idex_bubble});
        end
        step();
        ex_memRead = 1'b0; id_uses_rs1 = 1'b1;
        #1;
        n_cmp++; if (a_pc_write !== 1'b1) begin
            n_bad++; $display("FAIL nonload_nostall: got pc_write=%b want 1", a_pc_write);
        end
        step();
        n_cmp++; if (a_stall_count !== 16'd0) begin
            n_bad++; $display("FAIL nostall_count: got %0d want 0", a_stall_count);
        end
    endtask

    task automatic test_branch_lu();
        do_reset();
        ex_memRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; ex_branch_taken = 1'b1;
        #1;
        // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble}
        n_cmp++; if ({a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_ifid_flush, a_idex_bubble, a_memwb_bubble} !== 7'b1111110) begin
            n_bad++; $display("FAIL branch_lu_ctrl: got %b want 1111110", {a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_ifid_flush, a_idex_bubble, a_memwb_bubble});
        end
        step();
        n_cmp++; if (a_stall_count !== 16'd0) begin
            n_bad++; $display("FAIL branch_lu_count: got %0d want 0", a_stall_count);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            // {pc,ifid,idex,exmem writes, memwb_bubble, ifid_flush, idex_bubble}
            n_cmp++; if ({a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_memwb_bubble, a_ifid_flush, a_idex_bubble} !== 7'b0000100) begin
                n_bad++; $display("FAIL freeze_cycle%0d: got %b want 0000100", i, {a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_memwb_bubble, a_ifid_flush, a_idex_bubble});
            end
            step();
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if ({a_pc_write, a_exmem_write, a_memwb_bubble, a_ifid_flush, a_idex_bubble} !== 5'b11011) begin
            n_bad++; $display("FAIL freeze_release_branch: got %b want 11011", {a_pc_write, a_exmem_write, a_memwb_bubble, a_ifid_flush, a_idex_bubble});
        end
        step();
        n_cmp++; if (a_stall_count !== 16'd3) begin
            n_bad++; $display("FAIL freeze_count: got %0d want 3", a_stall_count);
        end
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b0;
        #1;
        n_cmp++; if (a_pc_write !== 1'b0 || a_memwb_bubble !== 1'b1) begin
            n_bad++; $display("FAIL back_to_back_freeze: got pc=%b mb=%b want 0 1", a_pc_write, a_memwb_bubble);
        end
        step();
        mem_ready = 1'b1;
        step();
        n_cmp++; if (a_stall_count !== 16'd4) begin
            n_bad++; $display("FAIL back_to_back_count: got %0d want 4", a_stall_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (b_pc_write !== 1'b0 || b_memwb_bubble !== 1'b1 || b_mem_timeout !== 1'b0) begin
                n_bad++; $display("FAIL timeout_frozen%0d: got pc=%b mb=%b to=%b want 0 1 0", i, b_pc_write, b_memwb_bubble, b_mem_timeout);
            end
            step();
        end
        n_cmp++; if ({b_mem_timeout, b_pc_write, b_exmem_write, b_memwb_bubble, b_ifid_flush, b_idex_bubble} !== 6'b100000) begin
            n_bad++; $display("FAIL fault_entry: got %b want 100000", {b_mem_timeout, b_pc_write, b_exmem_write, b_memwb_bubble, b_ifid_flush, b_idex_bubble});
        end
        n_cmp++; if (b_stall_count !== 16'd4 || a_mem_timeout !== 1'b0) begin
            n_bad++; $display("FAIL fault_count: got cnt=%0d default_to=%b want 4 0", b_stall_count, a_mem_timeout);
        end
        mem_req = 1'b0; mem_ready = 1'b1;
        step();
        step();
        n_cmp++; if (b_mem_timeout !== 1'b1 || b_pc_write !== 1'b0 || b_stall_count !== 16'd6) begin
            n_bad++; $display("FAIL fault_sticky: got to=%b pc=%b cnt=%0d want 1 0 6", b_mem_timeout, b_pc_write, b_stall_count);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (b_ifid_flush !== 1'b1 || b_memwb_bubble !== 1'b1) begin
            n_bad++; $display("FAIL fault_rst_ctrl: got flush=%b mb=%b want 1 1", b_ifid_flush, b_memwb_bubble);
        end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (b_mem_timeout !== 1'b0 || b_stall_count !== 16'd0 || b_pc_write !== 1'b1) begin
            n_bad++; $display("FAIL fault_recover: got to=%b cnt=%0d pc=%b want 0 0 1", b_mem_timeout, b_stall_count, b_pc_write);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) step();
        n_cmp++; if (c_stall_count !== 4'd15) begin
            n_bad++; $display("FAIL sat_reach: got %0d want 15", c_stall_count);
        end
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (c_stall_count !== 4'd15 || c_pc_write !== 1'b0 || c_mem_timeout !== 1'b0) begin
            n_bad++; $display("FAIL sat_hold: got cnt=%0d pc=%b to=%b want 15 0 0", c_stall_count, c_pc_write, c_mem_timeout);
        end
        n_cmp++; if (a_stall_count !== 16'd20) begin
            n_bad++; $display("FAIL wide_count: got %0d want 20", a_stall_count);
        end
    endtask

    task automatic test_rst_mid_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; mem_req = 1'b0;
        #1;
        n_cmp++; if (a_stall_count !== 16'd0 || a_pc_write !== 1'b1) begin
            n_bad++; $display("FAIL midwait_rst: got cnt=%0d pc=%b want 0 1", a_stall_count, a_pc_write);
        end
        for (int i = 0; i < 3; i++) begin
            mem_req = 1'b1; mem_ready = 1'b0;
            step();
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (b_pc_write !== 1'b1 || b_mem_timeout !== 1'b0) begin
            n_bad++; $display("FAIL midwait_waitcnt_cleared: got pc=%b to=%b want 1 0", b_pc_write, b_mem_timeout);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_rst_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
